// File: rtl/instr_issue_ctrl_pkg.sv
// Shared opcode constants, instruction field positions and the decoded-operand
// record used by the issue controller.
package instr_issue_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rt_use;
    logic [4:0] dest;
    logic       has_dest;
  } dec_t;

endpackage

// File: rtl/instr_issue_ctrl_fifo.sv
// Instruction buffer: power-of-two circular FIFO with an extra pointer bit to
// tell full from empty; flush empties it and drops any same-cycle push.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue controller: buffers fetched instructions, holds the head back on a RAW
// hazard against in-flight writers, and drives execute_unit with a registered bus.
module instr_issue_ctrl
  import instr_issue_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WB_LAT     = 2,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [31:0]      in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [31:0]      ex_instr,
  output logic             ex_valid,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int SB_N    = (WB_LAT > 1) ? WB_LAT - 1 : 1;
  localparam bit SB_LIVE = (WB_LAT > 1);

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] op;
    op       = ins[OP_HI:OP_LO];
    d.rs     = ins[RS_HI:RS_LO];
    d.rt     = ins[RT_HI:RT_LO];
    d.rt_use = 1'b0;
    d.dest   = 5'd0;
    case (op)
      OP_RTYPE: begin
        d.rt_use = 1'b1;
        d.dest   = ins[RD_HI:RD_LO];
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: d.dest = ins[RT_HI:RT_LO];
      OP_SW, OP_BEQ:                   d.rt_use = 1'b1;
      default: ;
    endcase
    d.has_dest = (d.dest != 5'd0);
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [31:0]      head;
  logic             fifo_full, fifo_empty, pop;
  dec_t             dec;
  logic             hazard;

  logic [31:0]      ex_instr_q, ex_instr_d;
  logic             ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [SB_N-1:0]  sb_v_q, sb_v_d;
  logic [4:0]       sb_dest_q [SB_N];
  logic [4:0]       sb_dest_d [SB_N];

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (rst),
    .push  (in_valid),
    .wdata (in_instr),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dec = decode(head);

  // $0 never matches: a stage only holds a valid entry when its dest is nonzero.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < SB_N; k++) begin
      if (sb_v_q[k] &&
          ((dec.rs != 5'd0 && sb_dest_q[k] == dec.rs) ||
           (dec.rt_use && dec.rt != 5'd0 && sb_dest_q[k] == dec.rt))) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    pop          = 1'b0;
    ex_instr_d   = NOP_INSTR;
    ex_valid_d   = 1'b0;
    issue_cnt_d  = issue_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    sb_v_d       = '0;
    sb_dest_d[0] = dec.dest;
    for (int k = 1; k < SB_N; k++) begin
      sb_v_d[k]    = sb_v_q[k-1];
      sb_dest_d[k] = sb_dest_q[k-1];
    end
    if (flush) begin
      sb_v_d = '0;
    end else if (!fifo_empty) begin
      if (hazard) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        pop         = 1'b1;
        ex_instr_d  = head;
        ex_valid_d  = 1'b1;
        sb_v_d[0]   = SB_LIVE && dec.has_dest;
        issue_cnt_d = sat_inc(issue_cnt_q);
      end
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ex_instr_q  <= NOP_INSTR;
      ex_valid_q  <= 1'b0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
      sb_v_q      <= '0;
    end else begin
      ex_instr_q  <= ex_instr_d;
      ex_valid_q  <= ex_valid_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      sb_v_q      <= sb_v_d;
    end
  end

  // Destination tags are qualified by sb_v_q, so they need no reset.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < SB_N; k++) begin
      sb_dest_q[k] <= sb_dest_d[k];
    end
  end

  assign in_ready  = !fifo_full;
  assign ex_instr  = ex_instr_q;
  assign ex_valid  = ex_valid_q;
  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign busy      = !fifo_empty || (|sb_v_q);

endmodule
